// File: rtl/parallel_link_ctrl.sv
// rtl/parallel_link_ctrl.sv - link supervisor sequencing clear, train, run and retry for parallel_send
module parallel_link_ctrl #(
   parameter int TRAIN_TIMEOUT = 4096,
   parameter int PULL_GAP      = 0,
   parameter int MAX_RETRY     = 7,
   parameter int ERR_LIMIT     = 3
) (
   input  logic        CLK,
   input  logic        RSTX,
   input  logic        START,
   input  logic        STOP,
   input  logic        RX_LOCKED,
   input  logic        RX_ERR,
   input  logic        DOPUSH,
   output logic        DOPULL,
   output logic        CLR,
   output logic        BUSY,
   output logic        LINK_UP,
   output logic        FAIL,
   output logic [3:0]  RETRY_CNT,
   output logic [31:0] WORD_CNT
);

   localparam int TW = (TRAIN_TIMEOUT > 1) ? $clog2(TRAIN_TIMEOUT) : 1;
   localparam int GW = (PULL_GAP > 0) ? $clog2(PULL_GAP + 1) : 1;
   localparam logic [TW-1:0] TIMER_LAST = TW'(TRAIN_TIMEOUT - 1);
   localparam logic [GW-1:0] GAP_LAST   = GW'(PULL_GAP);
   localparam logic [3:0]    RETRY_MAX  = 4'(MAX_RETRY);
   localparam logic [3:0]    ERR_MAX    = 4'(ERR_LIMIT);

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_TRAIN, S_RUN, S_BACKOFF, S_FAILED
   } state_t;

   state_t        state, state_nxt;
   logic [3:0]    phase_cnt, phase_nxt;
   logic [TW-1:0] timer, timer_nxt;
   logic [GW-1:0] gap_cnt, gap_nxt;
   logic [3:0]    err_cnt, err_nxt;
   logic [3:0]    retry_cnt, retry_nxt;
   logic [31:0]   word_cnt, word_nxt;
   logic [3:0]    err_inc;
   logic          retry_evt;

   always_ff @(posedge CLK or negedge RSTX) begin
      if (!RSTX) begin
         state     <= S_IDLE;
         phase_cnt <= '0;
         timer     <= '0;
         gap_cnt   <= '0;
         err_cnt   <= '0;
         retry_cnt <= '0;
         word_cnt  <= '0;
      end else begin
         state     <= state_nxt;
         phase_cnt <= phase_nxt;
         timer     <= timer_nxt;
         gap_cnt   <= gap_nxt;
         err_cnt   <= err_nxt;
         retry_cnt <= retry_nxt;
         word_cnt  <= word_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      phase_nxt = phase_cnt;
      timer_nxt = timer;
      gap_nxt   = gap_cnt;
      err_nxt   = err_cnt;
      retry_nxt = retry_cnt;
      word_nxt  = word_cnt;
      retry_evt = 1'b0;
      err_inc   = err_cnt + 4'(RX_ERR);

      // Pacing runs free through TRAIN and RUN; only TRAIN entry rewinds it.
      if (state == S_TRAIN || state == S_RUN)
         gap_nxt = (gap_cnt == GAP_LAST) ? '0 : gap_cnt + 1'b1;

      case (state)
         S_IDLE: begin
            if (START) begin
               state_nxt = S_CLEAR;
               phase_nxt = '0;
               retry_nxt = '0;
               word_nxt  = '0;
               err_nxt   = '0;
            end
         end
         S_CLEAR: begin
            if (phase_cnt == 4'd1) begin
               state_nxt = S_TRAIN;
               timer_nxt = '0;
               gap_nxt   = '0;
            end else begin
               phase_nxt = phase_cnt + 4'd1;
            end
         end
         S_TRAIN: begin
            if (RX_LOCKED) begin
               state_nxt = S_RUN;
               err_nxt   = '0;
            end else if (timer == TIMER_LAST) begin
               retry_evt = 1'b1;
            end else begin
               timer_nxt = timer + 1'b1;
            end
         end
         S_RUN: begin
            if (DOPUSH)
               word_nxt = word_cnt + 32'd1;
            err_nxt = err_inc;
            if (!RX_LOCKED || err_inc >= ERR_MAX)
               retry_evt = 1'b1;
         end
         S_BACKOFF: begin
            if (phase_cnt == 4'd15) begin
               state_nxt = S_CLEAR;
               phase_nxt = '0;
            end else begin
               phase_nxt = phase_cnt + 4'd1;
            end
         end
         S_FAILED: ;
         default: state_nxt = S_IDLE;
      endcase

      if (retry_evt) begin
         if (retry_cnt == RETRY_MAX) begin
            state_nxt = S_FAILED;
         end else begin
            state_nxt = S_BACKOFF;
            phase_nxt = '0;
            retry_nxt = (retry_cnt == 4'd15) ? 4'd15 : retry_cnt + 4'd1;
         end
      end

      if (STOP)
         state_nxt = S_IDLE;
   end

   assign DOPULL    = (state == S_TRAIN || state == S_RUN) && (gap_cnt == '0);
   assign CLR       = (state == S_CLEAR);
   assign BUSY      = (state != S_IDLE) && (state != S_FAILED);
   assign LINK_UP   = (state == S_RUN);
   assign FAIL      = (state == S_FAILED);
   assign RETRY_CNT = retry_cnt;
   assign WORD_CNT  = word_cnt;

endmodule
